// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding, requester indices and the memory-controller
// request record shared by the arbiter and its grant selector.
package mem_arb_pkg;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;

    localparam int MC_ADDR_W = 28;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic [MC_ADDR_W-1:0] addr;
        logic                 write;
        logic                 cacheID;
    } mc_req_t;

endpackage

// File: rtl/arb_grant_sel.sv
// arb_grant_sel: combinational grant choice. DCache outranks ICache unless the
// starvation override asks for ICache while it is requesting.
module arb_grant_sel
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
)
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               force_icache,
    output logic               gnt_any,
    output logic               gnt_idx,
    output logic [NUM_REQ-1:0] gnt_onehot
);

    always_comb begin
        gnt_any = |req_valid;
        gnt_idx = 1'(REQ_DCACHE);
        if (req_valid[REQ_ICACHE] && (force_icache || !req_valid[REQ_DCACHE]))
            gnt_idx = 1'(REQ_ICACHE);
        gnt_onehot = '0;
        if (gnt_any)
            gnt_onehot[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: serialises ICache/DCache line requests onto one memory controller.
// Define MEM_REQ_ARB_STARVE_GUARD_EN to bound how long ICache can be starved by DCache.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 28,
    parameter int PROG_W       = 10,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        IN_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] IN_req_addr,
    input  logic [NUM_REQ-1:0]        IN_req_write,
    output logic [NUM_REQ-1:0]        OUT_req_ready,
    output logic [NUM_REQ-1:0]        OUT_req_done,
    output logic [NUM_REQ-1:0]        OUT_req_abort,
    output logic [PROG_W-1:0]         OUT_progress,
    input  logic                      IN_flush,
    output logic                      OUT_MC_valid,
    output logic [ADDR_W-1:0]         OUT_MC_addr,
    output logic                      OUT_MC_write,
    output logic                      OUT_MC_cacheID,
    input  logic                      IN_MC_busy,
    input  logic                      IN_MC_cacheID,
    input  logic [PROG_W-1:0]         IN_MC_progress
);

    // The MC ID is a single bit, so exactly two requesters are supported.
    generate
        if (NUM_REQ != REQ_DCACHE + 1 || STARVE_LIMIT < 1 || ADDR_W < 1 ||
            ADDR_W > MC_ADDR_W || PROG_W < 1) begin : g_bad_params
            $error("mem_req_arbiter: unsupported parameter set");
        end
    endgenerate

    arb_state_e         state_q;
    arb_state_e         state_d;
    mc_req_t            mc_q;
    logic [NUM_REQ-1:0] abort_q;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ADDR_W-1:0]  sel_addr;
    logic               gnt_any;
    logic               gnt_idx;
    logic               force_icache;
    logic               grant_now;
    logic               issue_live;
    logic               mc_accept;

    arb_grant_sel #(.NUM_REQ(NUM_REQ)) u_grant_sel (
        .req_valid    (IN_req_valid),
        .force_icache (force_icache),
        .gnt_any      (gnt_any),
        .gnt_idx      (gnt_idx),
        .gnt_onehot   (gnt_onehot)
    );

    // Ready is a Mealy output of IDLE, so it is masked while reset is held.
    assign grant_now  = rst && (state_q == ST_IDLE) && gnt_any;
    assign issue_live = (state_q == ST_ISSUE) && !IN_flush;
    assign mc_accept  = issue_live && !IN_MC_busy;
    assign owner_oh   = NUM_REQ'(1) << mc_q.cacheID;
    assign sel_addr   = gnt_idx ? IN_req_addr[REQ_DCACHE*ADDR_W +: ADDR_W]
                                : IN_req_addr[REQ_ICACHE*ADDR_W +: ADDR_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gnt_any) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (IN_flush)
                    state_d = ST_IDLE;
                else if (mc_accept)
                    state_d = ST_WAIT;
            end
            // Another requester's transfer may still be draining; wait for ours.
            ST_WAIT:  if (IN_MC_busy && (IN_MC_cacheID == mc_q.cacheID)) state_d = ST_XFER;
            ST_XFER:  if (!IN_MC_busy) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mc_q    <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= ((state_q == ST_ISSUE) && IN_flush) ? owner_oh : '0;
            if (grant_now) begin
                mc_q.addr    <= MC_ADDR_W'(sel_addr);
                mc_q.write   <= IN_req_write[gnt_idx];
                mc_q.cacheID <= gnt_idx;
            end
        end
    end

`ifdef MEM_REQ_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;

    assign force_icache = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Counts DCache wins that left a waiting ICache request behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else if (grant_now) begin
            if (gnt_idx == 1'(REQ_ICACHE))
                starve_cnt_q <= '0;
            else if (IN_req_valid[REQ_ICACHE])
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end
`else
    assign force_icache = 1'b0;
`endif

    assign OUT_req_ready  = grant_now ? gnt_onehot : '0;
    assign OUT_req_done   = (state_q == ST_DONE) ? owner_oh : '0;
    assign OUT_req_abort  = abort_q;
    assign OUT_progress   = (state_q == ST_XFER) ? IN_MC_progress : '0;
    assign OUT_MC_valid   = issue_live;
    assign OUT_MC_addr    = mc_q.addr[ADDR_W-1:0];
    assign OUT_MC_write   = mc_q.write;
    assign OUT_MC_cacheID = mc_q.cacheID;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized bench for mem_req_arbiter against a transaction-level model.
// Build with MEM_REQ_ARB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_mem_req_arbiter;

    localparam int ADDR_W       = 28;
    localparam int PROG_W       = 10;
    localparam int STARVE_LIMIT = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            IN_req_valid;
    logic [2*ADDR_W-1:0]   IN_req_addr;
    logic [1:0]            IN_req_write;
    logic [1:0]            OUT_req_ready;
    logic [1:0]            OUT_req_done;
    logic [1:0]            OUT_req_abort;
    logic [PROG_W-1:0]     OUT_progress;
    logic                  IN_flush;
    logic                  OUT_MC_valid;
    logic [ADDR_W-1:0]     OUT_MC_addr;
    logic                  OUT_MC_write;
    logic                  OUT_MC_cacheID;
    logic                  IN_MC_busy;
    logic                  IN_MC_cacheID;
    logic [PROG_W-1:0]     IN_MC_progress;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] last_ready;

`ifdef MEM_REQ_ARB_STARVE_GUARD_EN
    int dcache_run = 0;
    int grant_order [6] = '{1, 1, 1, 1, 0, 1};
`else
    int grant_order [6] = '{1, 1, 1, 1, 1, 1};
`endif

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .NUM_REQ      (2),
        .ADDR_W       (ADDR_W),
        .PROG_W       (PROG_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IN_req_valid   (IN_req_valid),
        .IN_req_addr    (IN_req_addr),
        .IN_req_write   (IN_req_write),
        .OUT_req_ready  (OUT_req_ready),
        .OUT_req_done   (OUT_req_done),
        .OUT_req_abort  (OUT_req_abort),
        .OUT_progress   (OUT_progress),
        .IN_flush       (IN_flush),
        .OUT_MC_valid   (OUT_MC_valid),
        .OUT_MC_addr    (OUT_MC_addr),
        .OUT_MC_write   (OUT_MC_write),
        .OUT_MC_cacheID (OUT_MC_cacheID),
        .IN_MC_busy     (IN_MC_busy),
        .IN_MC_cacheID  (IN_MC_cacheID),
        .IN_MC_progress (IN_MC_progress)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // DCache wins by default; with the guard, a waiting ICache is served after STARVE_LIMIT DCache wins.
    task automatic predictGrant(input logic [1:0] valid, output int g);
        g = valid[1] ? 1 : 0;
`ifdef MEM_REQ_ARB_STARVE_GUARD_EN
        if (valid[0] && dcache_run == STARVE_LIMIT)
            g = 0;
        if (g == 0)
            dcache_run = 0;
        else if (valid[0])
            dcache_run++;
`endif
    endtask

    task automatic resetModel();
`ifdef MEM_REQ_ARB_STARVE_GUARD_EN
        dcache_run = 0;
`endif
    endtask

    // One complete request: grant in IDLE, ISSUE (optionally blocked or flushed), WAIT, XFER, DONE.
    task automatic applyStimulus(input logic [1:0] valid, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                 input logic [1:0] wr, input int foreign, input bit flush_issue,
                                 input int gap, input int busy_len, input bit flush_late);
        int                g;
        logic              gb;
        logic [1:0]        exp_oh;
        logic [ADDR_W-1:0] exp_addr;
        logic [PROG_W-1:0] prog;
        logic [PROG_W-1:0] exp_prog;

        predictGrant(valid, g);
        gb       = (g == 1);
        exp_oh   = gb ? 2'b10 : 2'b01;
        exp_addr = gb ? a1 : a0;

        @(negedge clk);
        IN_req_valid = valid;
        IN_req_addr  = {a1, a0};
        IN_req_write = wr;
        IN_flush     = 1'b0;
        IN_MC_busy   = 1'b0;
        #1;
        last_ready = OUT_req_ready;
        checkOutput("idle_grant", 64'({OUT_req_ready, OUT_req_done, OUT_req_abort, OUT_MC_valid}),
                    64'({exp_oh, 4'b0000, 1'b0}));

        for (int k = 0; k < foreign; k++) begin
            @(negedge clk);
            IN_req_valid  = 2'($urandom);
            IN_req_addr   = 56'({$urandom, $urandom});
            IN_MC_busy    = 1'b1;
            IN_MC_cacheID = ~gb;
            #1;
            checkOutput("issue_hold", 64'({OUT_req_ready, OUT_MC_valid, OUT_MC_addr, OUT_MC_write, OUT_MC_cacheID}),
                        64'({2'b00, 1'b1, exp_addr, wr[g], gb}));
        end

        @(negedge clk);
        IN_req_valid = 2'($urandom);
        IN_req_addr  = 56'({$urandom, $urandom});
        IN_flush     = flush_issue;
        IN_MC_busy   = flush_issue ? 1'($urandom) : 1'b0;
        #1;
        if (flush_issue) begin
            checkOutput("flush_drop", 64'({OUT_req_ready, OUT_MC_valid, OUT_req_abort}), 64'(0));
            @(negedge clk);
            IN_req_valid = 2'b00;
            IN_flush     = 1'b0;
            IN_MC_busy   = 1'b0;
            #1;
            checkOutput("abort_pulse", 64'({OUT_req_abort, OUT_req_done, OUT_MC_valid, OUT_req_ready}),
                        64'({exp_oh, 2'b00, 1'b0, 2'b00}));
        end else begin
            checkOutput("issue_accept", 64'({OUT_req_ready, OUT_MC_valid, OUT_MC_addr, OUT_MC_write, OUT_MC_cacheID}),
                        64'({2'b00, 1'b1, exp_addr, wr[g], gb}));

            for (int k = 0; k < gap; k++) begin
                @(negedge clk);
                IN_req_valid  = 2'($urandom);
                IN_MC_busy    = 1'($urandom);
                IN_MC_cacheID = ~gb;
                IN_flush      = flush_late;
                #1;
                checkOutput("wait_quiet", 64'({OUT_req_ready, OUT_MC_valid, OUT_progress, OUT_req_done, OUT_req_abort}), 64'(0));
            end

            for (int k = 0; k < busy_len; k++) begin
                @(negedge clk);
                IN_req_valid   = 2'($urandom);
                IN_MC_busy     = 1'b1;
                IN_MC_cacheID  = gb;
                prog           = PROG_W'($urandom);
                IN_MC_progress = prog;
                IN_flush       = flush_late;
                #1;
                exp_prog = (k == 0) ? '0 : prog;
                checkOutput("xfer_progress", 64'({OUT_req_ready, OUT_MC_valid, OUT_progress, OUT_req_done, OUT_req_abort}),
                            64'({2'b00, 1'b0, exp_prog, 4'b0000}));
            end

            @(negedge clk);
            IN_MC_busy     = 1'b0;
            prog           = PROG_W'($urandom);
            IN_MC_progress = prog;
            #1;
            checkOutput("xfer_fall", 64'({OUT_req_ready, OUT_MC_valid, OUT_progress, OUT_req_done, OUT_req_abort}),
                        64'({2'b00, 1'b0, prog, 4'b0000}));

            @(negedge clk);
            IN_req_valid = 2'($urandom);
            IN_flush     = flush_late;
            #1;
            checkOutput("done_pulse", 64'({OUT_req_done, OUT_req_ready, OUT_req_abort, OUT_MC_valid, OUT_progress}),
                        64'({exp_oh, 4'b0000, 1'b0, 10'd0}));
        end
    endtask

    initial begin
        rst            = 1'b0;
        IN_req_valid   = 2'b11;
        IN_req_addr    = 56'({$urandom, $urandom});
        IN_req_write   = 2'b11;
        IN_flush       = 1'b0;
        IN_MC_busy     = 1'b0;
        IN_MC_cacheID  = 1'b0;
        IN_MC_progress = 10'h3ff;
        #2;
        checkOutput("reset_outputs", 64'({OUT_req_ready, OUT_req_done, OUT_req_abort, OUT_progress,
                                          OUT_MC_valid, OUT_MC_addr, OUT_MC_write, OUT_MC_cacheID}), 64'(0));
        @(negedge clk);
        rst          = 1'b1;
        IN_req_valid = 2'b00;

        // Both requesters held: grant order exposes priority and the starvation guard.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b11, ADDR_W'($urandom), ADDR_W'($urandom), 2'($urandom),
                          0, 1'b0, $urandom_range(0, 2), $urandom_range(1, 3), 1'b0);
            checkOutput("grant_order", 64'(last_ready), 64'((grant_order[i] == 1) ? 2'b10 : 2'b01));
        end

        applyStimulus(2'b01, 28'h0000123, ADDR_W'($urandom), 2'b00, 0, 1'b0, 0, 4, 1'b0);
        applyStimulus(2'b11, ADDR_W'($urandom), ADDR_W'($urandom), 2'b10, 0, 1'b0, 1, 2, 1'b0);
        applyStimulus(2'b01, ADDR_W'($urandom), ADDR_W'($urandom), 2'b01, 0, 1'b0, 0, 2, 1'b0);
        applyStimulus(2'b10, ADDR_W'($urandom), ADDR_W'($urandom), 2'b10, 3, 1'b0, 1, 2, 1'b0);
        applyStimulus(2'b01, ADDR_W'($urandom), ADDR_W'($urandom), 2'b00, 1, 1'b1, 0, 1, 1'b0);
        applyStimulus(2'b10, ADDR_W'($urandom), ADDR_W'($urandom), 2'b10, 0, 1'b1, 0, 1, 1'b0);
        applyStimulus(2'b10, ADDR_W'($urandom), ADDR_W'($urandom), 2'b11, 0, 1'b0, 2, 3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(1, 3)), ADDR_W'($urandom), ADDR_W'($urandom), 2'($urandom),
                          $urandom_range(0, 2), ($urandom_range(0, 4) == 0), $urandom_range(0, 2),
                          $urandom_range(1, 4), 1'($urandom));
        end

        // Reset while a transfer is in flight: everything drops, no completion or abort afterwards.
        begin
            int g;
            predictGrant(2'b01, g);
            @(negedge clk);
            IN_req_valid = 2'b01;
            IN_flush     = 1'b0;
            IN_MC_busy   = 1'b0;
            #1;
            checkOutput("rst_seq_grant", 64'(OUT_req_ready), 64'((g == 1) ? 2'b10 : 2'b01));
            @(negedge clk);
            IN_req_valid = 2'b00;
            @(negedge clk);
            IN_MC_busy    = 1'b1;
            IN_MC_cacheID = 1'(g);
            @(negedge clk);
            IN_MC_progress = 10'h155;
            #1;
            checkOutput("rst_seq_xfer", 64'(OUT_progress), 64'(10'h155));
            IN_req_valid = 2'b11;
            #1;
            rst = 1'b0;
            #1;
            checkOutput("rst_mid_xfer", 64'({OUT_req_ready, OUT_req_done, OUT_req_abort, OUT_progress,
                                             OUT_MC_valid, OUT_MC_addr, OUT_MC_write, OUT_MC_cacheID}), 64'(0));
            resetModel();
            @(negedge clk);
            rst          = 1'b1;
            IN_req_valid = 2'b00;
            IN_MC_busy   = 1'b0;
            for (int k = 0; k < 3; k++) begin
                #1;
                checkOutput("post_rst_quiet", 64'({OUT_req_done, OUT_req_abort, OUT_MC_valid, OUT_progress}), 64'(0));
                @(negedge clk);
            end
        end

        applyStimulus(2'b11, ADDR_W'($urandom), ADDR_W'($urandom), 2'($urandom), 0, 1'b0, 0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2; number of requesters (0 = ICache fill, 1 = DCache fill/writeback).
REQ-002 The block SHALL have parameter ADDR_W, default 28; line address width.
REQ-003 The block SHALL have parameter PROG_W, default 10; MC progress width.
REQ-004 The block SHALL have parameter STARVE_LIMIT, default 4; consecutive req1 grants allowed while req0 waits.
REQ-005 The block SHALL have port clk, input, 1 bit; the only clock.
REQ-006 The block SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-007 The block SHALL have port IN_req_valid, input, NUM_REQ bits; per-requester request.
REQ-008 The block SHALL have port IN_req_addr, input, NUM_REQ*ADDR_W bits; per-requester line address.
REQ-009 The block SHALL have port IN_req_write, input, NUM_REQ bits; 1 = writeback, 0 = fill.
REQ-010 The block SHALL have port OUT_req_ready, output, NUM_REQ bits; one-hot accept pulse.
REQ-011 The block SHALL have port OUT_req_done, output, NUM_REQ bits; one-cycle completion pulse.
REQ-012 The block SHALL have port OUT_req_abort, output, NUM_REQ bits; one-cycle abort pulse.
REQ-013 The block SHALL have port OUT_progress, output, PROG_W bits; progress of the active transfer, 0 when none.
REQ-014 The block SHALL have port IN_flush, input, 1 bit; cancels a not-yet-accepted MC request.
REQ-015 The block SHALL have port OUT_MC_valid, output, 1 bit; request to the memory controller.
REQ-016 The block SHALL have port OUT_MC_addr, output, ADDR_W bits; MC line address.
REQ-017 The block SHALL have port OUT_MC_write, output, 1 bit; MC direction.
REQ-018 The block SHALL have port OUT_MC_cacheID, output, 1 bit; requester index sent to the MC.
REQ-019 The block SHALL have port IN_MC_busy, input, 1 bit; MC transfer active.
REQ-020 The block SHALL have port IN_MC_cacheID, input, 1 bit; ID of the active MC transfer.
REQ-021 The block SHALL have port IN_MC_progress, input, PROG_W bits; MC beat progress.

Function
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT, XFER and DONE.
REQ-023 In IDLE with any IN_req_valid, the block SHALL select grant g, pulse OUT_req_ready[g] in that cycle, latch addr/write/g, and enter ISSUE on the next edge.
REQ-024 The default priority SHALL be req1 over req0.
REQ-025 In ISSUE the block SHALL drive OUT_MC_valid=1 with the latched fields, and the MC SHALL accept when OUT_MC_valid && !IN_MC_busy, after which the block enters WAIT.
REQ-026 In WAIT, the block SHALL enter XFER when IN_MC_busy=1 and IN_MC_cacheID==g.
REQ-027 In XFER the block SHALL set OUT_progress=IN_MC_progress, and on IN_MC_busy falling it SHALL enter DONE.
REQ-028 DONE SHALL last one cycle, pulse OUT_req_done[g], and return to IDLE.
REQ-029 The earliest next grant after DONE SHALL be one cycle after DONE, in IDLE.
REQ-030 IN_flush in ISSUE, even in the MC-accept cycle, SHALL drop OUT_MC_valid, pulse OUT_req_abort[g] next cycle and return to IDLE without issuing.
REQ-031 IN_flush in WAIT, XFER or DONE SHALL be ignored.
REQ-032 OUT_MC_* fields SHALL be stable while OUT_MC_valid=1.
REQ-033 OUT_MC_valid SHALL be 0 outside ISSUE.
REQ-034 OUT_req_ready, OUT_req_done and OUT_req_abort SHALL each be at most one-hot.

Reset
REQ-035 On rst=0, asynchronously: state=IDLE, all outputs 0, latched fields 0, starvation counter 0.
REQ-036 Reset mid-transfer SHALL drop the transfer silently, with no done or abort pulse.

Configuration
REQ-037 With MEM_REQ_ARB_STARVE_GUARD_EN defined, the block SHALL increment a counter on each req1 grant while req0 is valid, clear it on any req0 grant, and when the counter equals STARVE_LIMIT grant req0 next, then clear the counter.
REQ-038 Without MEM_REQ_ARB_STARVE_GUARD_EN, the block SHALL use strict priority and have no counter.

Structure
REQ-039 Package mem_arb_pkg SHALL hold the FSM state enum, the requester index constants, and the MC request struct {addr, write, cacheID}.
REQ-040 Grant selection SHALL be the natural sub-module, arb_grant_sel: combinational priority plus starvation override.

Verification
REQ-041 Scenario: req0 only, addr 0x0000123, busy high 4 cycles -> ready[0] in cycle 0, MC_valid in cycle 1, done[0] one cycle after busy falls.
REQ-042 Scenario: req0 and req1 both valid in the same cycle -> ready=2'b10, OUT_MC_cacheID=1, and req0 is served after done[1].
REQ-043 Scenario: MC busy with a foreign ID when ISSUE is entered -> OUT_MC_valid is held with fields stable until busy=0.
REQ-044 Scenario: IN_flush in ISSUE -> abort[g] pulses, no MC accept, state returns to IDLE; IN_flush in XFER -> no effect, done[g] still pulses.
REQ-045 Scenario: with the guard enabled, req0 and req1 held valid -> grant order 1,1,1,1,0,1; without the guard -> 1,1,1,1,1,1.
REQ-046 Scenario: rst=0 asserted in XFER -> all outputs 0 immediately, no done or abort pulse.
